// File: rtl/boot_sequencer.sv
// Boot loader sequencer: receives a length-prefixed byte image, writes 16-bit words into
// code RAM, verifies an 8-bit additive checksum and then releases the core from reset.
module boot_sequencer #(
  parameter int unsigned MAX_WORDS = 8192,
  parameter int unsigned ADDR_W    = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reload,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] StLenLo  = 3'd0;
  localparam logic [2:0] StLenHi  = 3'd1;
  localparam logic [2:0] StDataLo = 3'd2;
  localparam logic [2:0] StDataHi = 3'd3;
  localparam logic [2:0] StCsum   = 3'd4;
  localparam logic [2:0] StRun    = 3'd5;
  localparam logic [2:0] StError  = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [16:0]       idx_q, idx_d;
  logic [7:0]        lsb_q, lsb_d;
  logic [7:0]        csum_q, csum_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [15:0]       wdata_d;
  logic [31:0]       len_full;
  logic              accept;

  assign accept   = rx_valid & rx_ready;
  assign len_full = {16'h0000, rx_data, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    lsb_d   = lsb_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = ram_addr;
    wdata_d = ram_wdata;
    if (reload) begin
      // A byte accepted alongside reload is dropped, and so is its write.
      state_d = StLenLo;
      len_d   = 16'h0000;
      idx_d   = 17'd0;
      lsb_d   = 8'h00;
      csum_d  = 8'h00;
    end else if (accept) begin
      case (state_q)
        StLenLo: begin
          len_d   = {8'h00, rx_data};
          state_d = StLenHi;
        end
        StLenHi: begin
          len_d   = len_full[15:0];
          idx_d   = 17'd0;
          state_d = (len_full == 32'd0 || len_full > MAX_WORDS) ? StError : StDataLo;
        end
        StDataLo: begin
          lsb_d   = rx_data;
          csum_d  = csum_q + rx_data;
          state_d = StDataHi;
        end
        StDataHi: begin
          csum_d  = csum_q + rx_data;
          we_d    = 1'b1;
          addr_d  = idx_q[ADDR_W-1:0];
          wdata_d = {rx_data, lsb_q};
          idx_d   = idx_q + 17'd1;
          state_d = (idx_d == {1'b0, len_q}) ? StCsum : StDataLo;
        end
        StCsum: state_d = (rx_data == csum_q) ? StRun : StError;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StLenLo;
      len_q     <= 16'h0000;
      idx_q     <= 17'd0;
      lsb_q     <= 8'h00;
      csum_q    <= 8'h00;
      rx_ready  <= 1'b1;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= 16'h0000;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      lsb_q     <= lsb_d;
      csum_q    <= csum_d;
      // Outputs are registered from the next state so they line up with state_q.
      rx_ready  <= (state_d != StRun) && (state_d != StError);
      ram_we    <= we_d;
      ram_addr  <= addr_d;
      ram_wdata <= wdata_d;
      cpu_reset <= (state_d != StRun);
      done      <= (state_d == StRun);
      error     <= (state_d == StError);
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: streams images byte by byte and checks writes and status.
module tb_boot_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reload = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        ram_we;
  logic [12:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [12:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];

  boot_sequencer #(.MAX_WORDS(8192), .ADDR_W(13)) dut (
    .clk(clk), .reset(reset), .reload(reload), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wr_addr_q.push_back(ram_addr);
      wr_data_q.push_back(ram_wdata);
    end
  end

  // Called at a negedge; presents one byte for one rising edge and returns at the next negedge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'hxx;
  endtask

  task automatic idle_gap(input int max_gap);
    int n;
    n = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (n) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic send_basic(input logic [7:0] csum, input int max_gap);
    logic [7:0] img[7];
    img = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h00};
    img[6] = csum;
    for (int i = 0; i < 7; i++) begin
      idle_gap(max_gap);
      send_byte(img[i]);
    end
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_basic_writes(input string tag);
    checks++;
    if (wr_addr_q.size() !== 2) begin
      errors++;
      $display("FAIL %s write count: got %0d want 2", tag, wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 13'h0000 || wr_data_q[0] !== 16'h1234) begin
        errors++;
        $display("FAIL %s write0: got %h=%h want 0000=1234", tag, wr_addr_q[0], wr_data_q[0]);
      end
      checks++;
      if (wr_addr_q[1] !== 13'h0001 || wr_data_q[1] !== 16'h5678) begin
        errors++;
        $display("FAIL %s write1: got %h=%h want 0001=5678", tag, wr_addr_q[1], wr_data_q[1]);
      end
    end
  endtask

  task automatic check_run(input string tag);
    checks++;
    if ({done, cpu_reset, rx_ready, error} !== 4'b1000) begin
      errors++;
      $display("FAIL %s run status {done,cpu_reset,rx_ready,error}: got %b want 1000", tag,
               {done, cpu_reset, rx_ready, error});
    end
  endtask

  task automatic check_loading(input string tag);
    checks++;
    if ({done, cpu_reset, rx_ready, error, ram_we} !== 5'b01100) begin
      errors++;
      $display("FAIL %s load status {done,cpu_reset,rx_ready,error,ram_we}: got %b want 01100",
               tag, {done, cpu_reset, rx_ready, error, ram_we});
    end
  endtask

  task automatic check_error(input string tag);
    checks++;
    if ({done, cpu_reset, rx_ready, error} !== 4'b0101) begin
      errors++;
      $display("FAIL %s error status {done,cpu_reset,rx_ready,error}: got %b want 0101", tag,
               {done, cpu_reset, rx_ready, error});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_loading("reset");
    checks++;
    if (ram_addr !== 13'h0000 || ram_wdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset ram bus: got %h/%h want 0000/0000", ram_addr, ram_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
    check_loading("reset_release");
  endtask

  task automatic test_basic();
    clear_log();
    send_basic(8'h14, 0);
    check_basic_writes("basic");
    check_run("basic");
    repeat (3) @(negedge clk);
    check_run("basic_hold");
  endtask

  task automatic test_reload_run_and_bad_csum();
    do_reload();
    check_loading("reload_from_run");
    clear_log();
    send_basic(8'h15, 0);
    check_basic_writes("bad_csum");
    check_error("bad_csum");
    repeat (4) @(negedge clk);
    check_error("bad_csum_hold");
    do_reload();
    check_loading("reload_from_error");
  endtask

  task automatic test_length();
    logic [7:0] sum;
    logic [15:0] w;
    clear_log();
    send_byte(8'h00);
    send_byte(8'h00);
    check_error("len_zero");
    checks++;
    if (ram_we !== 1'b0 || wr_addr_q.size() !== 0) begin
      errors++;
      $display("FAIL len_zero write: got we=%b count=%0d want 0/0", ram_we, wr_addr_q.size());
    end
    do_reload();
    send_byte(8'h01);
    send_byte(8'h20);
    check_error("len_2001");
    do_reload();
    clear_log();
    sum = 8'h00;
    send_byte(8'h00);
    send_byte(8'h20);
    for (int i = 0; i < 8192; i++) begin
      w = 16'(i) ^ 16'hA5C3;
      send_byte(w[7:0]);
      send_byte(w[15:8]);
      sum = sum + w[7:0] + w[15:8];
    end
    send_byte(sum);
    check_run("len_2000");
    checks++;
    if (wr_addr_q.size() !== 8192) begin
      errors++;
      $display("FAIL len_2000 write count: got %0d want 8192", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[8191] !== 13'h1FFF || wr_data_q[8191] !== (16'h1FFF ^ 16'hA5C3)) begin
        errors++;
        $display("FAIL len_2000 last write: got %h=%h want 1fff=%h", wr_addr_q[8191],
                 wr_data_q[8191], 16'h1FFF ^ 16'hA5C3);
      end
    end
  endtask

  task automatic test_gaps();
    for (int r = 0; r < 3; r++) begin
      do_reload();
      clear_log();
      send_basic(8'h14, 5);
      check_basic_writes("gaps");
      check_run("gaps");
    end
  endtask

  task automatic test_reset_mid_write();
    do_reload();
    clear_log();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h34);
    rx_valid = 1'b1;
    rx_data  = 8'h12;
    reset    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    rx_valid = 1'b0;
    check_loading("reset_mid");
    checks++;
    if (ram_addr !== 13'h0000 || wr_addr_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_mid write: got addr=%h count=%0d want 0000/0", ram_addr,
               wr_addr_q.size());
    end
    @(negedge clk);
    check_loading("reset_mid_next");
    send_basic(8'h14, 0);
    check_basic_writes("reset_mid_reload");
    check_run("reset_mid_reload");
  endtask

  task automatic test_reload_with_byte();
    do_reload();
    clear_log();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h34);
    rx_valid = 1'b1;
    rx_data  = 8'h12;
    reload   = 1'b1;
    @(negedge clk);
    reload   = 1'b0;
    rx_valid = 1'b0;
    check_loading("reload_byte");
    @(negedge clk);
    checks++;
    if (wr_addr_q.size() !== 0) begin
      errors++;
      $display("FAIL reload_byte write count: got %0d want 0", wr_addr_q.size());
    end
    send_basic(8'h14, 0);
    check_basic_writes("reload_byte_next");
    check_run("reload_byte_next");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_reload_run_and_bad_csum();
    test_length();
    test_gaps();
    test_reset_mid_write();
    test_reload_with_byte();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
